seg7_capture: RTL and testbench



---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_inverse.sv | 36 +++
 rtl/seg7_capture.sv | 164 ++++++++++++++++
 tb/tb_seg7_capture.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the forward decoder and the readback capture block.
// Holds the active-high segment patterns (bit0=a .. bit6=g, bit7=DP) and the capture FSM state type.
// Both directions use these constants, so the two tables cannot drift apart.
package seg7_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_0     = 8'h3F;
  localparam seg_t SEG_1     = 8'h06;
  localparam seg_t SEG_2     = 8'h5B;
  localparam seg_t SEG_3     = 8'h4F;
  localparam seg_t SEG_4     = 8'h66;
  localparam seg_t SEG_5     = 8'h6D;
  localparam seg_t SEG_6     = 8'h7D;
  localparam seg_t SEG_7     = 8'h07;
  localparam seg_t SEG_8     = 8'h7F;
  localparam seg_t SEG_9     = 8'h6F;
  localparam seg_t SEG_A     = 8'h77;
  localparam seg_t SEG_B     = 8'h7C;
  localparam seg_t SEG_C     = 8'h39;
  localparam seg_t SEG_D     = 8'h5E;
  localparam seg_t SEG_E     = 8'h79;
  localparam seg_t SEG_F     = 8'h71;
  localparam seg_t SEG_BLANK = 8'h00;

  // Capture FSM: wait for a one-hot strobe, debounce, write once, hold until the bus moves.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/seg7_inverse.sv
// Combinational inverse 7-segment decoder: segment pattern -> hex nibble plus match flag.
// Ports: seg_i (pattern, DP must already be cleared by the caller), hit_o (pattern is a hex digit),
//        nib_o (decoded nibble, 0 when hit_o is low).
module seg7_inverse
  import seg7_pkg::*;
(
  input  seg_t       seg_i,
  output logic       hit_o,
  output logic [3:0] nib_o
);

  always_comb begin
    hit_o = 1'b1;
    nib_o = 4'h0;
    case (seg_i)
      SEG_0:   nib_o = 4'h0;
      SEG_1:   nib_o = 4'h1;
      SEG_2:   nib_o = 4'h2;
      SEG_3:   nib_o = 4'h3;
      SEG_4:   nib_o = 4'h4;
      SEG_5:   nib_o = 4'h5;
      SEG_6:   nib_o = 4'h6;
      SEG_7:   nib_o = 4'h7;
      SEG_8:   nib_o = 4'h8;
      SEG_9:   nib_o = 4'h9;
      SEG_A:   nib_o = 4'hA;
      SEG_B:   nib_o = 4'hB;
      SEG_C:   nib_o = 4'hC;
      SEG_D:   nib_o = 4'hD;
      SEG_E:   nib_o = 4'hE;
      SEG_F:   nib_o = 4'hF;
      default: hit_o = 1'b0;   // blank and any other pattern
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Readback of a multiplexed active-high 7-segment bus: debounces each strobe window, inverse-decodes
// the pattern and stores nibble/valid/DP per digit; frame_done pulses once every digit has been captured.
// Ports: clk, reset_n (sync, active-low), leds[7:0], digit[NDIG-1:0] in; nums, valid, dp, frame_done,
//        err_cnt out. Optional macro SEG7_CAPTURE_ERRCNT_EN enables the saturating undecodable-pattern count.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        leds,
  input  logic [NDIG-1:0]   digit,
  output logic [4*NDIG-1:0] nums,
  output logic [NDIG-1:0]   valid,
  output logic [NDIG-1:0]   dp,
  output logic              frame_done,
  output logic [7:0]        err_cnt
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  seg_t            smp_leds_q, ref_leds_q;
  logic [NDIG-1:0] smp_digit_q, ref_digit_q;
  cap_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [NDIG-1:0] seen_q;
  logic [4*NDIG-1:0] nums_q;
  logic [NDIG-1:0] valid_q, dp_q;
  logic            frame_done_q;

  logic            onehot, changed;
  logic [CW-1:0]   cnt_inc;
  cap_state_e      restart_state;
  logic [CW-1:0]   restart_cnt;
  logic [IW-1:0]   cap_idx;
  logic [NDIG-1:0] seen_next;
  logic            inv_hit;
  logic [3:0]      inv_nib;

  // Input sampling stage; everything downstream sees only the registered bus.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      smp_leds_q  <= SEG_BLANK;
      smp_digit_q <= '0;
    end else begin
      smp_leds_q  <= leds;
      smp_digit_q <= digit;
    end
  end

  always_comb begin
    onehot  = (smp_digit_q != '0) && ((smp_digit_q & (smp_digit_q - NDIG'(1))) == '0);
    changed = (smp_leds_q != ref_leds_q) || (smp_digit_q != ref_digit_q);
    cnt_inc = (cnt_q == CW'(STABLE_CYCLES)) ? cnt_q : cnt_q + CW'(1);
    // A new window counts its first sample; with STABLE_CYCLES=1 that sample is already enough.
    restart_state = S_IDLE;
    restart_cnt   = '0;
    if (onehot) begin
      restart_state = (STABLE_CYCLES <= 1) ? S_CAPTURE : S_SETTLE;
      restart_cnt   = CW'(1);
    end
    cap_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (ref_digit_q[i]) cap_idx = IW'(i);
    end
    seen_next = seen_q | ref_digit_q;
  end

  // DP is stripped so the decoder sees the pure segment pattern.
  seg7_inverse u_inv (
    .seg_i ({1'b0, ref_leds_q[6:0]}),
    .hit_o (inv_hit),
    .nib_o (inv_nib)
  );

  // ref_* holds the previous sample while debouncing and is frozen during CAPTURE, so the write uses
  // the debounced window and a bus change on the capture cycle is still seen as a change in HOLD.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ref_leds_q   <= SEG_BLANK;
      ref_digit_q  <= '0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      seen_q       <= '0;
      nums_q       <= '0;
      valid_q      <= '0;
      dp_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (state_q != S_CAPTURE) begin
        ref_leds_q  <= smp_leds_q;
        ref_digit_q <= smp_digit_q;
      end
      case (state_q)
        S_IDLE: begin
          state_q <= restart_state;
          cnt_q   <= restart_cnt;
        end
        S_SETTLE: begin
          if (changed) begin
            state_q <= restart_state;
            cnt_q   <= restart_cnt;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc >= CW'(STABLE_CYCLES)) state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          dp_q[cap_idx] <= ref_leds_q[7];
          if (inv_hit) begin
            nums_q[{cap_idx, 2'b00} +: 4] <= inv_nib;
            valid_q[cap_idx]              <= 1'b1;
          end else begin
            valid_q[cap_idx] <= 1'b0;
          end
          // The completing digit starts the next frame from an empty mask.
          if (seen_next == '1) begin
            frame_done_q <= 1'b1;
            seen_q       <= '0;
          end else begin
            seen_q <= seen_next;
          end
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (changed) begin
            state_q <= restart_state;
            cnt_q   <= restart_cnt;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef SEG7_CAPTURE_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_cnt_q <= 8'h00;
    end else if (state_q == S_CAPTURE && !inv_hit && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

  assign nums       = nums_q;
  assign valid      = valid_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture (NDIG=4, STABLE_CYCLES=4): directed windows then random windows,
// compared every cycle against a run-length reference model of the strobe bus.
// Ports driven: clk, reset_n, leds, digit; all outputs observed on the falling edge.
module tb_seg7_capture;

  localparam int NDIG   = 4;
  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  leds;
  logic [3:0]  digit;
  logic [15:0] nums;
  logic [3:0]  valid, dp;
  logic        frame_done;
  logic [7:0]  err_cnt;

  seg7_capture #(.NDIG(NDIG), .STABLE_CYCLES(STABLE)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .leds       (leds),
    .digit      (digit),
    .nums       (nums),
    .valid      (valid),
    .dp         (dp),
    .frame_done (frame_done),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model. A window of identical one-hot samples is captured once, when its run length
  // reaches STABLE; the outputs change two clocks after that sample entered on the pins.
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    int         at;
    logic [7:0] l;
    logic [3:0] d;
  } wr_t;

  wr_t        pend[$];
  logic [3:0] m_nums [4];
  logic [3:0] m_valid, m_dp, m_seen;
  logic       m_frame;
  int         m_err;
  int         edge_no;
  int         run;
  logic       last_ok;
  logic [7:0] last_l;
  logic [3:0] last_d;
  int         fcount;

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m_nums[i] = 4'h0;
    m_valid = '0; m_dp = '0; m_seen = '0; m_frame = 1'b0; m_err = 0;
    run = 0; last_ok = 1'b0; last_l = '0; last_d = '0;
    pend.delete();
  endfunction

  function automatic void apply_write(input logic [7:0] l, input logic [3:0] d);
    int idx = 0;
    int hit = -1;
    for (int i = 0; i < 4; i++) if (d[i]) idx = i;
    for (int k = 0; k < 16; k++) if (hex_tab[k] == l[6:0]) hit = k;
    m_dp[idx] = l[7];
    if (hit >= 0) begin
      m_nums[idx]  = 4'(hit);
      m_valid[idx] = 1'b1;
    end else begin
      m_valid[idx] = 1'b0;
      if (m_err < 255) m_err++;
    end
    m_seen = m_seen | d;
    if (m_seen == 4'hF) begin
      m_frame = 1'b1;
      m_seen  = '0;
    end
  endfunction

  function automatic void model_edge(input logic [7:0] l, input logic [3:0] d, input logic rn);
    logic oh;
    edge_no++;
    if (!rn) begin
      model_clear();
      return;
    end
    m_frame = 1'b0;
    while (pend.size() > 0 && pend[0].at == edge_no) begin
      wr_t w = pend.pop_front();
      apply_write(w.l, w.d);
    end
    oh = ($countones(d) == 1);
    if (oh && last_ok && l == last_l && d == last_d) run++;
    else run = oh ? 1 : 0;
    last_ok = oh; last_l = l; last_d = d;
    if (run == STABLE) pend.push_back('{edge_no + 2, l, d});
  endfunction

  task automatic compare_all();
    logic [15:0] exp_nums;
    int          exp_err;
    for (int i = 0; i < 4; i++) exp_nums[4*i +: 4] = m_nums[i];
`ifdef SEG7_CAPTURE_ERRCNT_EN
    exp_err = m_err;
`else
    exp_err = 0;
`endif
    check("nums", 32'(nums), 32'(exp_nums));
    check("valid", 32'(valid), 32'(m_valid));
    check("dp", 32'(dp), 32'(m_dp));
    check("frame_done", 32'(frame_done), 32'(m_frame));
    check("err_cnt", 32'(err_cnt), 32'(exp_err));
  endtask

  // Called at a falling edge: drive, clock, model, then observe at the next falling edge.
  task automatic tick(input logic [7:0] l, input logic [3:0] d, input logic rn);
    leds = l; digit = d; reset_n = rn;
    @(posedge clk);
    model_edge(l, d, rn);
    @(negedge clk);
    compare_all();
    if (frame_done) fcount++;
  endtask

  task automatic window(input logic [7:0] l, input logic [3:0] d, input int n);
    repeat (n) tick(l, d, 1'b1);
  endtask

  initial begin
    logic [7:0] pl, l;
    logic [3:0] pd, d;
    int         len;

    leds = '0; digit = '0; reset_n = 1'b0; edge_no = 0; fcount = 0;
    model_clear();
    @(negedge clk);

    // Reset held during an active strobe, then a short window that must not capture.
    tick(8'h3F, 4'b0001, 1'b0);
    tick(8'h3F, 4'b0001, 1'b0);
    check("rst_nums", 32'(nums), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_frame", 32'(frame_done), 32'h0);
    check("rst_err", 32'(err_cnt), 32'h0);
    window(8'h3F, 4'b0001, 3);
    check("post_rst_nocap", 32'(valid), 32'h0);

    // Basic scan of 1,2,3,4.
    fcount = 0;
    window(8'h06, 4'b0001, 8);
    window(8'h5B, 4'b0010, 8);
    window(8'h4F, 4'b0100, 8);
    window(8'h66, 4'b1000, 8);
    check("scan_nums", 32'(nums), 32'h4321);
    check("scan_valid", 32'(valid), 32'hF);
    check("scan_frames", 32'(fcount), 32'd1);

    // Short 8 glitch followed by a stable 9.
    window(8'h7F, 4'b0010, 3);
    window(8'h6F, 4'b0010, 6);
    check("glitch_nib1", 32'(nums[7:4]), 32'h9);

    // Blank and undecodable patterns on digit 2.
    window(8'h00, 4'b0100, 8);
    window(8'h06, 4'b1000, 6);
    window(8'h49, 4'b0100, 8);
    check("blank_valid2", 32'(valid[2]), 32'h0);
    check("blank_nib2", 32'(nums[11:8]), 32'h3);
`ifdef SEG7_CAPTURE_ERRCNT_EN
    check("blank_err", 32'(err_cnt), 32'd2);
`endif

    // Two strobes at once: nothing changes.
    window(8'h06, 4'b0110, 10);
    check("multi_nums", 32'(nums), 32'h1391);
    check("multi_valid", 32'(valid), 32'hB);

    // Zero with DP held for a long window.
    window(8'hBF, 4'b0001, 20);
    check("dp_nib0", 32'(nums[3:0]), 32'h0);
    check("dp_dp0", 32'(dp[0]), 32'h1);
    check("dp_valid0", 32'(valid[0]), 32'h1);

    // Random windows: short glitches or windows at least one sample longer than the debounce time.
    pl = 8'hBF; pd = 4'b0001;
    for (int w = 0; w < 250; w++) begin
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(1, 2)) tick(8'($urandom), 4'($urandom), 1'b0);
        continue;
      end
      if ($urandom_range(0, 4) != 0) d = 4'(1 << $urandom_range(0, 3));
      else d = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 6))
        0:       l = 8'h00;
        1:       l = 8'($urandom);
        default: l = {1'($urandom_range(0, 1)), hex_tab[$urandom_range(0, 15)]};
      endcase
      if (l == pl && d == pd) l = l ^ 8'h80;
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1, STABLE - 1);
      else len = $urandom_range(STABLE + 1, STABLE + 8);
      window(l, d, len);
      pl = l; pd = d;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
